// File: rtl/pic_pkg.sv
// Shared types and helpers for the PIC interrupt-acknowledge service path.
package pic_pkg;

   localparam int NUM_IR = 8;
   localparam int LVL_W  = 3;

   localparam logic [LVL_W-1:0] SPURIOUS_LVL = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK1 = 2'd1,
      GAP  = 2'd2,
      ACK2 = 2'd3
   } pic_state_e;

   // Returns {found, index} of the lowest-index set bit (IR0 is highest priority).
   function automatic logic [LVL_W:0] prio_enc(input logic [NUM_IR-1:0] v);
      logic [LVL_W:0] r;
      r = '0;
      for (int i = NUM_IR - 1; i >= 0; i--) begin
         if (v[i]) r = {1'b1, LVL_W'(i)};
      end
      return r;
   endfunction

   function automatic logic [NUM_IR-1:0] onehot(input logic [LVL_W-1:0] lvl);
      return NUM_IR'(1) << lvl;
   endfunction

endpackage

// File: rtl/pic_prio_enc8.sv
// Combinational lowest-index priority encoder over eight request levels.
module pic_prio_enc8
   import pic_pkg::*;
(
   input  logic [NUM_IR-1:0] vec,
   output logic              found,
   output logic [LVL_W-1:0]  idx
);

   logic [LVL_W:0] enc;

   always_comb begin
      enc   = prio_enc(vec);
      found = enc[LVL_W];
      idx   = enc[LVL_W-1:0];
   end

endmodule

// File: rtl/pic_inta_sequencer.sv
// 8259-style service side: raises INT, runs the two-pulse INTA handshake,
// maintains the ISR and drives the interrupt vector.
//
// state | meaning
// IDLE  | int_out follows pending-request evaluation, waiting for first INTA
// ACK1  | first INTA low, level frozen and ISR bit set
// GAP   | between pulses, waiting for second INTA
// ACK2  | second INTA low, vector driven on data bus
module pic_inta_sequencer
   import pic_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_IR-1:0] irr_req,
   input  logic [4:0]        vector_base,
   input  logic              auto_eoi,
   input  logic              inta_n,
   input  logic              eoi_valid,
   input  logic              eoi_specific,
   input  logic [LVL_W-1:0]  eoi_level,
   output logic              int_out,
   output logic [NUM_IR-1:0] irr_clear,
   output logic [NUM_IR-1:0] isr,
   output logic [7:0]        data_out,
   output logic              data_oe
);

   pic_state_e        state;
   logic              inta_prev;
   logic [LVL_W-1:0]  ack_lvl;
   logic              ack_spur;

   logic              fall;
   logic              rise;
   logic              req_found;
   logic [LVL_W-1:0]  req_idx;
   logic              isr_found;
   logic [LVL_W-1:0]  isr_idx;
   logic [LVL_W:0]    hp_isr;
   logic              int_cand;
   logic              ack_take;
   logic [NUM_IR-1:0] eoi_clr;
   logic [NUM_IR-1:0] aeoi_clr;
   logic [NUM_IR-1:0] isr_set;
   logic [NUM_IR-1:0] isr_next;

   pic_prio_enc8 u_req_enc (
      .vec   (irr_req),
      .found (req_found),
      .idx   (req_idx)
   );

   pic_prio_enc8 u_isr_enc (
      .vec   (isr),
      .found (isr_found),
      .idx   (isr_idx)
   );

   always_comb begin
      fall   = inta_prev & ~inta_n;
      rise   = ~inta_prev & inta_n;
      hp_isr = isr_found ? {1'b0, isr_idx} : (LVL_W + 1)'(NUM_IR);

      int_cand = 1'b0;
      for (int i = 0; i < NUM_IR; i++) begin
         if (irr_req[i] && (i < int'(hp_isr))) int_cand = 1'b1;
      end
      ack_take = int_cand & req_found;
   end

   // EOI works on the pre-update ISR; a same-cycle set is ORed in last so it wins.
   always_comb begin
      eoi_clr = '0;
      if (eoi_valid) begin
         if (eoi_specific)   eoi_clr = onehot(eoi_level);
         else if (isr_found) eoi_clr = onehot(isr_idx);
      end

      aeoi_clr = '0;
      if (state == ACK2 && rise && auto_eoi && !ack_spur) aeoi_clr = onehot(ack_lvl);

      isr_set = '0;
      if (state == IDLE && fall && ack_take) isr_set = onehot(req_idx);

      isr_next = (isr & ~eoi_clr & ~aeoi_clr) | isr_set;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         isr       <= '0;
         int_out   <= 1'b0;
         irr_clear <= '0;
         data_out  <= '0;
         data_oe   <= 1'b0;
         inta_prev <= 1'b1;
         ack_lvl   <= '0;
         ack_spur  <= 1'b0;
      end else begin
         inta_prev <= inta_n;
         isr       <= isr_next;
         irr_clear <= '0;
         case (state)
            IDLE: begin
               int_out <= int_cand & ~fall;
               if (fall) begin
                  state <= ACK1;
                  if (ack_take) begin
                     ack_lvl   <= req_idx;
                     ack_spur  <= 1'b0;
                     irr_clear <= onehot(req_idx);
                  end else begin
                     ack_lvl  <= SPURIOUS_LVL;
                     ack_spur <= 1'b1;
                  end
               end
            end
            ACK1: begin
               int_out <= 1'b0;
               if (rise) state <= GAP;
            end
            GAP: begin
               int_out <= 1'b0;
               if (fall) begin
                  state    <= ACK2;
                  data_out <= {vector_base, ack_lvl};
                  data_oe  <= 1'b1;
               end
            end
            ACK2: begin
               int_out <= 1'b0;
               if (rise) begin
                  state    <= IDLE;
                  data_out <= '0;
                  data_oe  <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               int_out <= 1'b0;
            end
         endcase
      end
   end

endmodule
